sram_bus_responder: RTL
=======================

// Module: sram_bus_responder
// PURPOSE
//  Synthesizable responder for the external SRAM bus driven by the memory controller.
//  Decodes an address window on addrBus and serves reads/writes from an internal word array.
//  Replaces the off-chip SRAM in on-FPGA builds and memory-mapped test fixtures.
//  Provides a side preload port so boot images can be loaded while the bus is idle.
// PARAMETERS
//  ADDR_W    8      word-address bits decoded locally; DEPTH = 2**ADDR_W words
//  BASE_HI   0      required value of addrBus[17:ADDR_W] (window select)
//  READ_LAT  1      cycles from read-strobe sample to data drive (0..15)
// PORTS
//  clk        input   1   system clock, all logic on posedge
//  rst        input   1   asynchronous, active-low reset
//  addrBus    input   18  bus word address
//  dataBus    inout   16  bus data; driven only in READ_DRIVE, else 'z
//  memEnable  input   1   chip enable, active-low
//  memRead    input   1   output enable, active-low
//  memWrite   input   1   write enable, active-low
//  loadEn     input   1   preload request (one word per cycle when accepted)
//  loadAddr   input   ADDR_W  preload word address
//  loadData   input   16  preload data
//  loadStall  output  1   1 = preload rejected this cycle (bus busy)
//  busy       output  1   1 = state != IDLE
//  readCount  output  16  accepted bus reads (see CONFIGURATION)
//  writeCount output  16  committed bus writes (see CONFIGURATION)
// BEHAVIOUR
//  - Input stage: addrBus/dataBus/strobes registered once; all decisions use sampled values.
//  - hit = en==0 && addr[17:ADDR_W]==BASE_HI; miss => no drive, no write, state unchanged.
//  - FSM: IDLE, READ_WAIT, READ_DRIVE, WRITE_HOLD.
//  - IDLE: hit & wr==0 -> WRITE_HOLD (wr wins if rd also 0); hit & rd==0 -> READ_WAIT,
//    latch addr, load latency counter with READ_LAT; READ_LAT==0 goes straight to READ_DRIVE.
//  - READ_WAIT: counter decrements each cycle; at 0 -> READ_DRIVE. Strobe release -> IDLE.
//  - READ_DRIVE: dataOe=1, dataBus=mem[latched addr]. Sampled addr change while held ->
//    relatch, READ_WAIT. rd or en released, or wr asserted -> IDLE, dataOe=0 same edge.
//  - WRITE_HOLD: latch addr on entry; dataBus sampled every cycle. On wr or en release,
//    commit last sampled data while held to mem[latched addr] at that edge -> IDLE.
//    Addr change while held: commit old word, relatch, stay.
//  - Total read latency: strobe at bus -> data on bus = 1 (input reg) + READ_LAT + 1 cycles.
//  - Preload: accepted only in IDLE with no hit this cycle; else loadStall=1, no write.
//  - Reset (mid-op included): state IDLE, dataOe=0 (bus 'z), busy=0, loadStall=0,
//    counters 0; pending write discarded; array contents NOT reset.
// CONFIGURATION
//  SRAM_RESP_STATS_EN defined: readCount +1 per IDLE/READ_DRIVE->READ_WAIT entry;
//    writeCount +1 per commit; both saturate at 16'hFFFF.
//  Not defined: readCount/writeCount tied to 16'h0000, no counter flops.
// TESTING
//  1. Preload addr 3=16'hBEEF, bus read 0x00003 (READ_LAT=1) -> 'z until 3rd edge, then BEEF.
//  2. Write 0x00005=16'h1234 (wr held 2 cycles, release) -> readback 1234; busy drops after release.
//  3. addrBus=0x10005 (BASE_HI mismatch), rd=0 -> dataBus stays 'z, busy=0, no count.
//  4. Held read, addr 3->4 mid-drive -> one WAIT cycle, then mem[4]; readCount +2 (STATS_EN).
//  5. loadEn during WRITE_HOLD -> loadStall=1, target word unchanged.
//  6. rst low in READ_DRIVE -> dataBus 'z immediately; in WRITE_HOLD -> no commit.

Source files
------------

// File: rtl/sram_bus_responder.sv
// On-chip stand-in for the external SRAM: windowed bus decode, read latency, write-on-release, side preload.
// Define SRAM_RESP_STATS_EN to build saturating read/write activity counters.
module sram_bus_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned BASE_HI  = 0,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [17:0]       addrBus,
  inout  wire  [15:0]       dataBus,
  input  logic              memEnable,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              loadEn,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [15:0]       loadData,
  output logic              loadStall,
  output logic              busy,
  output logic [15:0]       readCount,
  output logic [15:0]       writeCount
);

  localparam int unsigned BUS_AW = 18;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned HI_W   = BUS_AW - ADDR_W;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE_HOLD} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ADDR_W-1:0]   lat_addr, lat_addr_nxt;
  logic [DATA_W-1:0]   wr_data, wr_data_nxt;
  logic                commit;
  logic                data_oe;

  logic [BUS_AW-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                en_q, rd_q, wr_q;
  logic                hit;
  logic [ADDR_W-1:0]   local_addr;
  logic                load_ok;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Bus input stage; strobes idle high out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= '0;
      en_q   <= 1'b1;
      rd_q   <= 1'b1;
      wr_q   <= 1'b1;
    end else begin
      addr_q <= addrBus;
      data_q <= dataBus;
      en_q   <= memEnable;
      rd_q   <= memRead;
      wr_q   <= memWrite;
    end
  end

  assign hit        = !en_q && (addr_q[BUS_AW-1:ADDR_W] == HI_W'(BASE_HI));
  assign local_addr = addr_q[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      data_oe  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lat_addr <= lat_addr_nxt;
      wr_data  <= wr_data_nxt;
      busy     <= (state_nxt != IDLE);
      data_oe  <= (state_nxt == READ_DRIVE);
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_addr_nxt = lat_addr;
    wr_data_nxt  = wr_data;
    commit       = 1'b0;
    case (state)
      IDLE: begin
        if (hit && !wr_q) begin
          state_nxt    = WRITE_HOLD;
          lat_addr_nxt = local_addr;
          wr_data_nxt  = data_q;
        end else if (hit && !rd_q) begin
          lat_addr_nxt = local_addr;
          cnt_nxt      = CNT_W'(READ_LAT);
          state_nxt    = (READ_LAT == 0) ? READ_DRIVE : READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (!hit || rd_q) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state_nxt = READ_DRIVE;
        end
      end
      READ_DRIVE: begin
        if (!hit || rd_q || !wr_q) begin
          state_nxt = IDLE;
        end else if (local_addr != lat_addr) begin
          lat_addr_nxt = local_addr;
          cnt_nxt      = CNT_W'(READ_LAT);
          state_nxt    = READ_WAIT;
        end
      end
      WRITE_HOLD: begin
        // The word captured while the strobe was still held is what gets committed
        if (!hit || wr_q) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end else if (local_addr != lat_addr) begin
          commit       = 1'b1;
          lat_addr_nxt = local_addr;
          wr_data_nxt  = data_q;
        end else begin
          wr_data_nxt  = data_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load_ok   = loadEn && (state == IDLE) && !hit;
  assign loadStall = loadEn && !load_ok;

  // Word array is deliberately left unreset
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[lat_addr] <= wr_data;
    end else if (load_ok) begin
      mem[loadAddr] <= loadData;
    end
  end

  assign dataBus = data_oe ? mem[lat_addr] : 'z;

`ifdef SRAM_RESP_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;
  logic        rd_evt;

  assign rd_evt = ((state_nxt == READ_WAIT) && (state != READ_WAIT)) ||
                  ((state == IDLE) && (state_nxt == READ_DRIVE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_evt && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
      if (commit && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign readCount  = rd_cnt;
  assign writeCount = wr_cnt;
`else
  assign readCount  = 16'h0000;
  assign writeCount = 16'h0000;
`endif

endmodule
